branch_resolve_unit: RTL and testbench

- Sits between the IF-stage branch predictor table and the EX-stage branch comparator.
- Captures each IF-stage prediction snapshot (table index, bank select, 2-bit counter) into an in-flight queue.
- When EX resolves the oldest branch, computes the saturating counter update, drives the predictor's write port, and flags mispredictions for pipeline flush.

---
 rtl/bp_pkg.sv | 33 +++
 rtl/bp_snapshot_fifo.sv | 53 +++++
 rtl/branch_resolve_unit.sv | 97 +++++++++
 tb/tb_branch_resolve_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch resolve path.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package bp_pkg;

    // Predictor table index width; the unit's IDX_W parameter must match it
    // because the snapshot record is declared here.
    localparam int BP_IDX_W = 4;

    // 2-bit saturating counter encodings; bit 1 is the predicted direction.
    localparam logic [1:0] STRONG_NT = 2'd0;
    localparam logic [1:0] WEAK_NT   = 2'd1;
    localparam logic [1:0] WEAK_T    = 2'd2;
    localparam logic [1:0] STRONG_T  = 2'd3;

    // One in-flight branch: where its counter lives, what was read, and the
    // direction IF actually followed.
    typedef struct packed {
        logic [BP_IDX_W-1:0] index;
        logic                sel;
        logic [1:0]          counter;
        logic                pred_dir;
    } bp_snapshot_t;

    // Saturating increment on taken, saturating decrement on not taken.
    function automatic logic [1:0] sat_update(input logic [1:0] c, input logic taken);
        logic [1:0] r;
        if (taken) r = (c == STRONG_T)  ? STRONG_T  : c + 2'd1;
        else       r = (c == STRONG_NT) ? STRONG_NT : c - 2'd1;
        return r;
    endfunction

endpackage

// File: rtl/bp_snapshot_fifo.sv
// Circular FIFO of prediction snapshots with a single-cycle flush.
// Latency: head is combinational from storage; push visible at head the next cycle.
// Backpressure: full blocks pushes (dropped if attempted); flush wins over a same-cycle push.
module bp_snapshot_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    // Pointer and occupancy tracking; flush empties the queue outright.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Snapshot storage; contents need no reset since count guards reads.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Tracks IF predictions until EX resolves them, writes back counters, flags mispredicts.
// Latency: 1 cycle from resolving pop to update/mispredict pulse.
// Backpressure: if_ready low when queue full (IF must stall); ex_valid on empty is ignored.
// Optional: define BP_RESOLVE_FWD_EN to forward an in-progress counter write into a same-index push.
module branch_resolve_unit
    import bp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IDX_W = BP_IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_valid,
    input  logic [IDX_W-1:0] if_index,
    input  logic             if_sel,
    input  logic [1:0]       if_counter,
    output logic             if_ready,
    output logic             pred_taken,
    input  logic             ex_valid,
    input  logic             ex_taken,
    output logic [IDX_W-1:0] index_ex,
    output logic             sel,
    output logic [1:0]       counter_out,
    output logic             update,
    output logic             T,
    output logic             mispredict,
    output logic             empty
);

    localparam int SW = $bits(bp_snapshot_t);

    bp_snapshot_t push_snap;
    bp_snapshot_t head_snap;
    logic [SW-1:0] head_vec;
    logic          full;
    logic          pop;
    logic          mis_now;
    logic [1:0]    eff_counter;

    // Counter the IF stage should believe: the table read, unless the
    // write landing this cycle targets the same entry (the read is stale).
    always_comb begin
        eff_counter = if_counter;
`ifdef BP_RESOLVE_FWD_EN
        if (update && (index_ex == if_index) && (sel == if_sel))
            eff_counter = counter_out;
`endif
    end

    assign pred_taken = eff_counter[1];
    assign if_ready   = !full;
    assign pop        = ex_valid && !empty;
    assign head_snap  = bp_snapshot_t'(head_vec);
    assign mis_now    = pop && (head_snap.pred_dir != ex_taken);

    assign push_snap.index    = if_index;
    assign push_snap.sel      = if_sel;
    assign push_snap.counter  = eff_counter;
    assign push_snap.pred_dir = eff_counter[1];

    bp_snapshot_fifo #(
        .DEPTH (DEPTH),
        .W     (SW)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (mis_now),
        .push     (if_valid),
        .push_dat (push_snap),
        .pop      (pop),
        .pop_dat  (head_vec),
        .full     (full),
        .empty    (empty)
    );

    // Register the predictor write and mispredict pulse one cycle after the pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            update      <= 1'b0;
            mispredict  <= 1'b0;
            T           <= 1'b0;
            counter_out <= 2'd0;
            index_ex    <= '0;
            sel         <= 1'b0;
        end else begin
            update     <= pop;
            mispredict <= mis_now;
            if (pop) begin
                T           <= ex_taken;
                counter_out <= sat_update(head_snap.counter, ex_taken);
                index_ex    <= head_snap.index;
                sel         <= head_snap.sel;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       if_valid;
    logic [3:0] if_index;
    logic       if_sel;
    logic [1:0] if_counter;
    logic       if_ready;
    logic       pred_taken;
    logic       ex_valid;
    logic       ex_taken;
    logic [3:0] index_ex;
    logic       sel;
    logic [1:0] counter_out;
    logic       update;
    logic       T;
    logic       mispredict;
    logic       empty;

    int checks = 0;
    int errors = 0;

    branch_resolve_unit #(.DEPTH(4), .IDX_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_valid    (if_valid),
        .if_index    (if_index),
        .if_sel      (if_sel),
        .if_counter  (if_counter),
        .if_ready    (if_ready),
        .pred_taken  (pred_taken),
        .ex_valid    (ex_valid),
        .ex_taken    (ex_taken),
        .index_ex    (index_ex),
        .sel         (sel),
        .counter_out (counter_out),
        .update      (update),
        .T           (T),
        .mispredict  (mispredict),
        .empty       (empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] idx;
        logic       s;
        logic [1:0] ctr;
        logic       taken;
        logic [1:0] exp_ctr;
        logic       exp_mis;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_valid = 1'b0;
        ex_valid = 1'b0;
        ex_taken = 1'b0;
    endtask

    task automatic drive_push(input logic [3:0] idx, input logic s, input logic [1:0] ctr);
        if_valid   = 1'b1;
        if_index   = idx;
        if_sel     = s;
        if_counter = ctr;
    endtask

    logic exp_fwd_pred;
    logic [1:0] exp_fwd_ctr;
    logic exp_fwd_mis;

    initial begin
        vecs[0] = '{idx: 4'd5,  s: 1'b0, ctr: 2'd2, taken: 1'b1, exp_ctr: 2'd3, exp_mis: 1'b0};
        vecs[1] = '{idx: 4'd3,  s: 1'b1, ctr: 2'd3, taken: 1'b1, exp_ctr: 2'd3, exp_mis: 1'b0};
        vecs[2] = '{idx: 4'd9,  s: 1'b0, ctr: 2'd0, taken: 1'b0, exp_ctr: 2'd0, exp_mis: 1'b0};
        vecs[3] = '{idx: 4'd12, s: 1'b1, ctr: 2'd1, taken: 1'b1, exp_ctr: 2'd2, exp_mis: 1'b1};
        vecs[4] = '{idx: 4'd6,  s: 1'b1, ctr: 2'd2, taken: 1'b0, exp_ctr: 2'd1, exp_mis: 1'b1};
        vecs[5] = '{idx: 4'd15, s: 1'b0, ctr: 2'd1, taken: 1'b0, exp_ctr: 2'd0, exp_mis: 1'b0};

        rst = 1'b1;
        if_index = 4'd0;
        if_sel = 1'b0;
        if_counter = 2'd0;
        idle();
        step();
        step();
        check("rst_update", update, 0);
        check("rst_mis", mispredict, 0);
        check("rst_T", T, 0);
        check("rst_ctr", counter_out, 0);
        check("rst_idx", index_ex, 0);
        check("rst_sel", sel, 0);
        check("rst_empty", empty, 1);
        check("rst_ready", if_ready, 1);
        rst = 1'b0;
        step();

        // Single push then resolve, one branch per vector
        for (int i = 0; i < 6; i++) begin
            drive_push(vecs[i].idx, vecs[i].s, vecs[i].ctr);
            #1;
            check($sformatf("v%0d_pred", i), pred_taken, vecs[i].ctr[1]);
            step();
            idle();
            check($sformatf("v%0d_nonempty", i), empty, 0);
            ex_valid = 1'b1;
            ex_taken = vecs[i].taken;
            step();
            idle();
            check($sformatf("v%0d_update", i), update, 1);
            check($sformatf("v%0d_idx", i), index_ex, vecs[i].idx);
            check($sformatf("v%0d_sel", i), sel, vecs[i].s);
            check($sformatf("v%0d_ctr", i), counter_out, vecs[i].exp_ctr);
            check($sformatf("v%0d_T", i), T, vecs[i].taken);
            check($sformatf("v%0d_mis", i), mispredict, vecs[i].exp_mis);
            check($sformatf("v%0d_empty", i), empty, 1);
            step();
            check($sformatf("v%0d_pulse", i), update, 0);
        end

        // Mispredict flushes younger entry and a same-cycle push
        drive_push(4'd2, 1'b0, 2'd1);
        step();
        drive_push(4'd7, 1'b0, 2'd2);
        step();
        drive_push(4'd11, 1'b1, 2'd3);
        ex_valid = 1'b1;
        ex_taken = 1'b1;
        step();
        idle();
        check("flush_update", update, 1);
        check("flush_idx", index_ex, 2);
        check("flush_ctr", counter_out, 2);
        check("flush_mis", mispredict, 1);
        check("flush_empty", empty, 1);
        ex_valid = 1'b1;
        ex_taken = 1'b1;
        step();
        idle();
        check("flush_no_update", update, 0);
        check("flush_no_mis", mispredict, 0);
        step();

        // Fill to DEPTH, drop a fifth push, then drain back-to-back
        for (int i = 0; i < 4; i++) begin
            check($sformatf("fill%0d_ready", i), if_ready, 1);
            drive_push(4'(i + 1), 1'b0, 2'd2);
            step();
        end
        check("full_ready", if_ready, 0);
        drive_push(4'd9, 1'b1, 2'd0);
        step();
        idle();
        for (int i = 0; i < 4; i++) begin
            ex_valid = 1'b1;
            ex_taken = 1'b1;
            step();
            check($sformatf("drain%0d_update", i), update, 1);
            check($sformatf("drain%0d_idx", i), index_ex, i + 1);
            check($sformatf("drain%0d_ctr", i), counter_out, 3);
            check($sformatf("drain%0d_mis", i), mispredict, 0);
        end
        check("drain_empty", empty, 1);
        step();
        idle();
        check("drain_no_fifth", update, 0);
        step();

        // Reset with entries queued discards them
        for (int i = 0; i < 3; i++) begin
            drive_push(4'(i + 8), 1'b1, 2'd3);
            step();
        end
        idle();
        check("prerst_nonempty", empty, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_empty", empty, 1);
        check("midrst_update", update, 0);
        ex_valid = 1'b1;
        ex_taken = 1'b1;
        step();
        check("midrst_ex_empty_update", update, 0);
        step();
        idle();
        check("midrst_ex_empty_mis", mispredict, 0);
        step();

        // Same-entry push during counter write
`ifdef BP_RESOLVE_FWD_EN
        exp_fwd_pred = 1'b1;
        exp_fwd_ctr  = 2'd3;
        exp_fwd_mis  = 1'b0;
`else
        exp_fwd_pred = 1'b0;
        exp_fwd_ctr  = 2'd2;
        exp_fwd_mis  = 1'b1;
`endif
        drive_push(4'd4, 1'b1, 2'd3);
        step();
        idle();
        ex_valid = 1'b1;
        ex_taken = 1'b0;
        step();
        idle();
        check("fwd_setup_ctr", counter_out, 2);
        check("fwd_setup_update", update, 1);
        drive_push(4'd4, 1'b1, 2'd1);
        #1;
        check("fwd_pred", pred_taken, exp_fwd_pred);
        step();
        idle();
        ex_valid = 1'b1;
        ex_taken = 1'b1;
        step();
        idle();
        check("fwd_update", update, 1);
        check("fwd_ctr", counter_out, exp_fwd_ctr);
        check("fwd_mis", mispredict, exp_fwd_mis);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
